dac_send: RTL and testbench
===========================

# dac_send

Serializes 16-bit audio samples onto the codec DAC data line in left-justified format, the transmit counterpart to the ADC capture path. Accepts one mono sample per frame through a valid/ready stream and drives it on both channels. The codec is bus master (supplies BCLK and DACLRCK); this block samples both into the single system clock domain and shifts data on detected BCLK falling edges. It sits between the playback sample source (tone generator or loopback) and the `AUD_DACDAT` pin.

## Interface
- `N`, 16, sample width in bits; `N` ≤ BCLK periods per channel half-frame.
- `clk`  in  1  system clock (adc_clk, 18.432 MHz); must be ≥ 8× BCLK.
- `reset`  in  1  synchronous, active-high reset.
- `bclk`  in  1  codec bit clock (AUD_BCLK, 1.536 MHz, 32 BCLK per frame), asynchronous.
- `daclrc`  in  1  codec DAC LR clock (AUD_DACLRCK): low = left, high = right; asynchronous.
- `sample_data`  in  N  signed two's-complement sample.
- `valid`  in  1  `sample_data` is valid.
- `ready`  out  1  holding register empty; transfer when `valid && ready` on a `clk` edge.
- `dacdat`  out  1  serial data to AUD_DACDAT.
- `underrun`  out  1  one-cycle pulse: left half-frame started with the holding register empty.

## Operation
- `bclk` and `daclrc` each pass through a 2-flop synchronizer plus one history flop; `bclk_fall` = history high, synchronized low.
- `daclrc` is sampled only on `bclk_fall`; `lrc_edge` = sampled value differs from value at previous `bclk_fall`.
- Holding register `hold` + flag `hold_full`. `ready = !hold_full`. Handshake loads `hold`, sets `hold_full`.
- Frame register `frame` holds the sample for the current frame (both channels).
- FSM (`dac_state_t`):
  - `WAIT_LRC`: `dacdat` = 0; on `bclk_fall && lrc_edge` → `SHIFT`, load shift register, `bit_cnt` = N-1, drive MSB.
  - `SHIFT`: on each `bclk_fall` without `lrc_edge`: shift left, drive next bit, decrement `bit_cnt`; after LSB driven and `bit_cnt` = 0, next `bclk_fall` → `PAD`.
  - `PAD`: `dacdat` = 0 until `bclk_fall && lrc_edge` → `SHIFT` (same load as above).
  - `lrc_edge` in any state restarts `SHIFT` for the new channel (truncates a short half-frame).
- Load on left start (new `daclrc` = 0): if `hold_full`, `frame` ← `hold`, clear `hold_full`; else pulse `underrun`. Shift register ← `frame`.
- Load on right start (new `daclrc` = 1): shift register ← `frame` (mono duplicated).
- Simultaneous handshake and left-start consume in same cycle: consume old `hold`, then accept new data into `hold`; `hold_full` stays 1.
- Reset mid-operation: returns to `WAIT_LRC`; first `lrc_edge` seen only after two `bclk_fall` samples after reset.

## Timing
- Reset values: `dacdat` 0, `ready` 1, `underrun` 0, `frame` 0, `hold_full` 0, state `WAIT_LRC`.
- `bclk_fall` asserted 3 `clk` after the pin edge; `dacdat` updates on the following `clk` edge (≤ 4 `clk` after BCLK falls, < one BCLK half-period at 12 `clk`/BCLK).
- `ready` deasserts the cycle after a handshake; reasserts the cycle after the left-start load.
- Sample latency: accepted sample appears MSB-first at the next left half-frame start; at most one frame plus 4 `clk`.

## Configuration
- `DAC_UNDERRUN_MUTE_EN` defined: on underrun `frame` ← 0 (silence for that frame).
- Not defined: on underrun `frame` keeps its previous value (last sample repeated). `underrun` pulses in both builds.

## Structure
- `audio_pkg`: `dac_state_t` enum (`WAIT_LRC`, `SHIFT`, `PAD`), `SYNC_STAGES` = 2.
- Sub-module `sync_edge`: synchronizer + history flop, outputs synchronized level and fall pulse; instantiated for `bclk` and `daclrc`.

## Test plan
- Reset, BCLK 1.536 MHz, 32 BCLK/frame, push 16'hA5C3 → left and right slots both shift 1010_0101_1100_0011 MSB-first, sampled on BCLK rising.
- Push 16'h8001 then 16'h7FFE one frame apart → consecutive frames carry each; `ready` low between handshake and left-start.
- No push after 16'h1234 → `underrun` one pulse per left-start; slots carry 16'h1234 (default) or 16'h0000 (with `DAC_UNDERRUN_MUTE_EN`).
- `valid` held in the same cycle as left-start with `hold_full` = 1 → old sample played, new sample retained, `hold_full` stays 1.
- 24 BCLK per half-frame with N = 16 → 8 trailing zeros per slot; 12 BCLK per half-frame → 12 MSBs only, restart on `lrc_edge`.
- Assert `reset` mid-slot → `dacdat` 0 and `ready` 1 next cycle; output resumes cleanly at the second detected LRC edge.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the codec audio paths.
//   dac_state_t  : serializer state (WAIT_LRC, SHIFT, PAD)
//   SYNC_STAGES  : flops in each codec-clock synchronizer chain
package audio_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      WAIT_LRC = 2'd0,
      SHIFT    = 2'd1,
      PAD      = 2'd2
   } dac_state_t;

endpackage

// File: rtl/dac_send_if.sv
// dac_send_if: sample stream into the DAC serializer.
//   sample_data : N-bit signed sample
//   valid       : sample_data is valid (source)
//   ready       : sink can accept; a transfer happens on any clk edge where
//                 valid && ready. valid may not depend on ready; once raised,
//                 valid and sample_data hold until the transfer.
// Modports: master = sample source, slave = dac_send.
interface dac_send_if #(
   parameter int N = 16
);
   logic [N-1:0] sample_data;
   logic         valid;
   logic         ready;

   modport master (output sample_data, output valid, input ready);
   modport slave  (input sample_data, input valid, output ready);
endinterface

// File: rtl/sync_edge.sv
// sync_edge: brings an asynchronous codec clock into the clk domain.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input
//   level      : synchronized level
//   fall       : one-cycle pulse when the synchronized level goes 1 -> 0
module sync_edge
   import audio_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   hist;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
         hist <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         hist <= sync[SYNC_STAGES-1];
      end
   end

   assign level = sync[SYNC_STAGES-1];
   assign fall  = hist & ~level;

endmodule

// File: rtl/dac_send.sv
// dac_send: left-justified serializer for the codec DAC data line.
// One mono sample per frame is accepted on the stream and played on both
// channels, MSB first, starting at each DACLRCK transition. The codec owns
// BCLK and DACLRCK; both are synchronized and data changes on BCLK falls.
//   clk, reset  : system clock, synchronous active-high reset
//   bclk        : codec bit clock (async)
//   daclrc      : codec DAC LR clock, low = left, high = right (async)
//   stream      : sample input (dac_send_if.slave)
//   dacdat      : serial data to AUD_DACDAT
//   underrun    : one-cycle pulse, left half-frame began with no sample held
//   state       : current serializer state
// Build option DAC_UNDERRUN_MUTE_EN: on underrun the frame plays silence
// instead of repeating the previous sample.
module dac_send
   import audio_pkg::*;
#(
   parameter int N = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bclk,
   input  logic        daclrc,
   dac_send_if.slave   stream,
   output logic        dacdat,
   output logic        underrun,
   output dac_state_t  state
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);

   logic bclk_fall, bclk_level_unused;
   logic lrc_level, lrc_fall_unused;

   sync_edge u_bclk_sync (
      .clk(clk), .reset(reset), .din(bclk),
      .level(bclk_level_unused), .fall(bclk_fall)
   );

   sync_edge u_lrc_sync (
      .clk(clk), .reset(reset), .din(daclrc),
      .level(lrc_level), .fall(lrc_fall_unused)
   );

   // LRC is only looked at on BCLK falls. lrc_valid suppresses a false edge
   // against the reset value of lrc_last.
   logic lrc_last, lrc_valid, lrc_edge;

   always_ff @(posedge clk) begin
      if (reset) begin
         lrc_last  <= 1'b0;
         lrc_valid <= 1'b0;
      end else if (bclk_fall) begin
         lrc_last  <= lrc_level;
         lrc_valid <= 1'b1;
      end
   end

   assign lrc_edge = bclk_fall && lrc_valid && (lrc_level != lrc_last);

   // Holding register. At a left start the held sample moves into frame;
   // ready is bypassed high in that cycle so a new sample can land in hold
   // at the same edge and hold_full never drops.
   logic [N-1:0] hold;
   logic         hold_full, consume, accept;

   assign consume      = lrc_edge && !lrc_level && hold_full;
   assign stream.ready = !hold_full || consume;
   assign accept       = stream.valid && stream.ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         if (accept) begin
            hold      <= stream.sample_data;
            hold_full <= 1'b1;
         end else if (consume) begin
            hold_full <= 1'b0;
         end
      end
   end

   // Serializer FSM.
   dac_state_t    state_q, state_n;
   logic [N-1:0]  frame, frame_n, shreg, shreg_n;
   logic [CW-1:0] bit_cnt, cnt_n;
   logic          dacdat_q, dacdat_n, underrun_q, underrun_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WAIT_LRC;
         frame      <= '0;
         shreg      <= '0;
         bit_cnt    <= '0;
         dacdat_q   <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_n;
         frame      <= frame_n;
         shreg      <= shreg_n;
         bit_cnt    <= cnt_n;
         dacdat_q   <= dacdat_n;
         underrun_q <= underrun_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      frame_n    = frame;
      shreg_n    = shreg;
      cnt_n      = bit_cnt;
      dacdat_n   = dacdat_q;
      underrun_n = 1'b0;
      if (lrc_edge) begin
         // A channel boundary restarts shifting from any state, which also
         // truncates a half-frame shorter than N bits.
         if (!lrc_level) begin
            if (hold_full) begin
               frame_n = hold;
            end else begin
               underrun_n = 1'b1;
`ifdef DAC_UNDERRUN_MUTE_EN
               frame_n = '0;
`endif
            end
         end
         state_n  = SHIFT;
         cnt_n    = CNT_TOP;
         shreg_n  = frame_n;
         dacdat_n = frame_n[N-1];
      end else if (bclk_fall) begin
         unique case (state_q)
            SHIFT: begin
               if (bit_cnt == '0) begin
                  state_n  = PAD;
                  dacdat_n = 1'b0;
               end else begin
                  shreg_n  = {shreg[N-2:0], 1'b0};
                  dacdat_n = shreg[N-2];
                  cnt_n    = bit_cnt - 1'b1;
               end
            end
            default: dacdat_n = 1'b0;
         endcase
      end
   end

   assign dacdat   = dacdat_q;
   assign underrun = underrun_q;
   assign state    = state_q;

endmodule

// File: tb/tb_dac_send.sv
// tb_dac_send: codec model drives BCLK/DACLRCK; a reference model predicts
// each half-frame's bit stream and underrun flag into exp_q; a monitor
// collects DACDAT on BCLK rising edges and compares per half-frame.
module tb_dac_send;
   import audio_pkg::*;

   localparam int N = 16;
   localparam int W = 39;  // {underrun, len[5:0], bits[31:0]}

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       bclk = 1'b0;
   logic       daclrc = 1'b1;
   logic       dacdat, underrun;
   dac_state_t state;

   dac_send_if #(.N(N)) sif ();

   dac_send #(.N(N)) dut (
      .clk(clk), .reset(reset), .bclk(bclk), .daclrc(daclrc),
      .stream(sif), .dacdat(dacdat), .underrun(underrun), .state(state)
   );

   // ---------------- clock / codec ----------------
   always #5 clk = ~clk;

   int half_len = 32;
   int cur_len  = 32;

   initial begin
      #2;
      forever begin
         for (int h = 0; h < 2; h++) begin
            cur_len = half_len;
            daclrc  = h[0];
            repeat (cur_len) begin
               #60 bclk = 1'b1;
               #60 bclk = 1'b0;
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- counters ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [N-1:0] pend[$];
   logic [N-1:0] m_frame = '0;
   bit           chk_en = 1'b0;
   logic [W-1:0] exp_q[$];

   initial begin
      logic lr;
      int   len;
      bit   en, u;
      forever begin
         @(daclrc);
         lr  = daclrc;
         len = cur_len;
         en  = chk_en;
         repeat (6) @(posedge clk);
         #3;
         u = 1'b0;
         if (!lr) begin
            if (pend.size() > 0) begin
               m_frame = pend.pop_front();
            end else begin
               u = 1'b1;
`ifdef DAC_UNDERRUN_MUTE_EN
               m_frame = '0;
`endif
            end
         end
         if (en) exp_q.push_back({u, 6'(len), m_frame, 16'h0000});
      end
   end

   // ---------------- monitor ----------------
   logic [31:0] got_bits = '0;
   int          got_len = 0;
   int          u_cnt = 0;
   bit          slot_en = 1'b0;

   always @(posedge bclk) begin
      if (got_len < 32) got_bits[31 - got_len] = dacdat;
      got_len++;
   end

   always @(negedge clk) begin
      if (underrun) u_cnt++;
   end

   initial begin
      logic [W-1:0] e;
      logic [31:0]  mask;
      forever begin
         @(daclrc);
         if (slot_en) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL exp_q_empty: got output slot, required an expectation");
            end else begin
               e = exp_q.pop_front();
               if (chk_en) begin
                  mask = '0;
                  for (int i = 0; i < 32; i++) if (i < int'(e[37:32])) mask[31 - i] = 1'b1;
                  check("slot_len", 64'(got_len), 64'(e[37:32]));
                  check("slot_bits", 64'(got_bits & mask), 64'(e[31:0] & mask));
                  check("slot_underrun", 64'(u_cnt), 64'(e[38]));
               end
            end
         end
         slot_en  = chk_en;
         got_bits = '0;
         got_len  = 0;
         u_cnt    = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push(input logic [N-1:0] d);
      int t;
      @(negedge clk);
      sif.sample_data = d;
      sif.valid = 1'b1;
      t = 0;
      while (!sif.ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!sif.ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL push_timeout: ready=%0b after %0d cycles, required 1", sif.ready, t);
         sif.valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         pend.push_back(d);
         sif.valid = 1'b0;
         @(negedge clk);
         check("ready_after_hs", 64'(sif.ready), 64'(0));
      end
   endtask

   task automatic safe_point();
      @(posedge daclrc);
      repeat (20) @(negedge clk);
   endtask

   task automatic wait_halves(input int n);
      repeat (n) @(daclrc);
   endtask

   // ---------------- main sequence ----------------
   int lens[4] = '{16, 20, 24, 32};

   initial begin
      sif.valid = 1'b0;
      sif.sample_data = '0;

      repeat (30) @(negedge clk);
      check("reset_dacdat", 64'(dacdat), 64'(0));
      check("reset_ready", 64'(sif.ready), 64'(1));
      check("reset_underrun", 64'(underrun), 64'(0));
      check("reset_state", 64'(state), 64'(WAIT_LRC));
      reset = 1'b0;

      wait_halves(2);
      repeat (20) @(negedge clk);
      chk_en = 1'b1;

      // basic pattern on both channels
      safe_point();
      push(16'hA5C3);
      wait_halves(4);

      // back-to-back frames, ready low until the left start
      safe_point();
      push(16'h8001);
      repeat (30) @(negedge clk);
      check("ready_low_pending", 64'(sif.ready), 64'(0));
      safe_point();
      push(16'h7FFE);
      wait_halves(4);

      // underrun repeats (or mutes) the last sample
      safe_point();
      push(16'h1234);
      wait_halves(8);

      // new sample offered while hold is full, accepted at the left start
      safe_point();
      push(16'hA1A1);
      push(16'hB2B2);
      wait_halves(4);

      // 24 BCLK per half-frame: trailing zeros
      safe_point();
      half_len = 24;
      repeat (3) begin
         safe_point();
         push(N'($urandom_range(0, 65535)));
      end
      // 12 BCLK per half-frame: truncated slots
      half_len = 12;
      repeat (3) begin
         safe_point();
         push(N'($urandom_range(0, 65535)));
      end
      // random lengths, occasional underrun
      repeat (6) begin
         safe_point();
         half_len = lens[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) != 0) push(N'($urandom_range(0, 65535)));
      end
      safe_point();
      half_len = 32;
      wait_halves(3);

      // reset in the middle of a left slot
      @(negedge daclrc);
      repeat (40) @(negedge clk);
      chk_en = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("midreset_dacdat", 64'(dacdat), 64'(0));
      check("midreset_ready", 64'(sif.ready), 64'(1));
      check("midreset_state", 64'(state), 64'(WAIT_LRC));
      repeat (3) @(negedge clk);
      reset = 1'b0;
      pend.delete();
      m_frame = '0;
      wait_halves(2);
      repeat (20) @(negedge clk);
      chk_en = 1'b1;
      safe_point();
      push(N'($urandom_range(0, 65535)));
      wait_halves(4);
      safe_point();
      push(N'($urandom_range(0, 65535)));
      wait_halves(4);

      // drain
      repeat (20) @(negedge clk);
      chk_en = 1'b0;
      wait_halves(2);
      check("exp_q_drained", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
